// File: rtl/system_led_sequencer_pkg.sv
// Shared encodings for the system LED sequencer: operating modes,
// config register map and controller states.
package system_led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A CTRL value that should have the sequencer stepping on its own.
    function automatic logic startsRun(input logic enable, input mode_e mode);
        return enable && (mode != MODE_STATIC);
    endfunction

endpackage

// File: rtl/system_led_sequencer_if.sv
// Minimal Avalon-MM write/read bus used both for the CPU config port
// and for the PIO data register port.
interface system_led_seq_avalon_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/system_led_sequencer_prescaler.sv
// Step prescaler: counts while running and flags a step whenever the
// count reaches the programmed period, giving a step every period+1 cycles.
module system_led_prescaler #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run_i,
    input  logic                    clear_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    step_o
);

    logic [PERIOD_WIDTH-1:0] count_q;
    logic                    atPeriod;

    assign atPeriod = (count_q == period_i);
    assign step_o   = run_i && atPeriod;

    // Count up while running, wrap on the step, and restart from zero on any clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (run_i) begin
            if (atPeriod) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/system_led_sequencer.sv
// Autonomous LED pattern controller: CPU programs mode/period/pattern over
// the config slave; the block pushes every new LED value to the PIO data
// register with a single zero-wait write.
module system_led_sequencer #(
    parameter int                   LED_WIDTH    = 8,
    parameter int                   PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0] RESET_PERIOD = 24'd5_000_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    system_led_seq_avalon_if.slave     cfg,
    system_led_seq_avalon_if.master    pio,
    output logic                       step_pulse
);

    import system_led_seq_pkg::*;

    logic                    ctrlEnable_q,  ctrlEnable_d;
    mode_e                   ctrlMode_q,    ctrlMode_d;
    logic [PERIOD_WIDTH-1:0] period_q,      period_d;
    logic [LED_WIDTH-1:0]    pattern_q,     pattern_d;
    logic [LED_WIDTH-1:0]    cur_q,         cur_d;
    logic [7:0]              stepCount_q,   stepCount_d;
    state_e                  state_q,       state_d;
    logic                    pioWrite_q,    pioWrite_d;
    logic [LED_WIDTH-1:0]    pioData_q,     pioData_d;

    logic        cfgWrite;
    logic        ctrlWrite;
    logic        periodWrite;
    logic        patternWrite;
    logic        newEnable;
    mode_e       newMode;
    logic        enterRun;
    logic        stepHit;
    logic        stepTaken;
    logic        prescalerClear;
    logic [31:0] readWord;
    logic [31:0] pioWord;
    logic        unusedBits;

    assign cfgWrite     = cfg.chipselect && !cfg.write_n;
    assign ctrlWrite    = cfgWrite && (cfg.address == REG_CTRL);
    assign periodWrite  = cfgWrite && (cfg.address == REG_PERIOD);
    assign patternWrite = cfgWrite && (cfg.address == REG_PATTERN);
    assign newEnable    = cfg.writedata[0];
    assign newMode      = mode_e'(cfg.writedata[2:1]);
    assign enterRun     = ctrlWrite && (state_q == ST_IDLE) && startsRun(newEnable, newMode);

    // A pattern write owns cur this cycle, so a coincident step is dropped.
    assign stepTaken      = stepHit && !patternWrite;
    assign prescalerClear = periodWrite || patternWrite || enterRun;
    assign step_pulse     = stepHit;

    // High config data bits and PIO read data carry nothing for this block.
    assign unusedBits = ^{pio.readdata, cfg.writedata[31:PERIOD_WIDTH]};

    system_led_prescaler #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .run_i    (state_q == ST_RUN),
        .clear_i  (prescalerClear),
        .period_i (period_q),
        .step_o   (stepHit)
    );

    // Next-state logic: register writes, run/idle transitions, cur loads and steps, PIO write request.
    always_comb begin
        ctrlEnable_d = ctrlEnable_q;
        ctrlMode_d   = ctrlMode_q;
        period_d     = period_q;
        pattern_d    = pattern_q;
        cur_d        = cur_q;
        stepCount_d  = stepCount_q;
        state_d      = state_q;
        pioWrite_d   = 1'b0;

        if (ctrlWrite) begin
            ctrlEnable_d = newEnable;
            ctrlMode_d   = newMode;
            case (state_q)
                ST_IDLE: if (startsRun(newEnable, newMode)) state_d = ST_RUN;
                default: if (!startsRun(newEnable, newMode)) state_d = ST_IDLE;
            endcase
        end

        if (periodWrite) begin
            period_d = cfg.writedata[PERIOD_WIDTH-1:0];
        end

        if (patternWrite) begin
            pattern_d  = cfg.writedata[LED_WIDTH-1:0];
            cur_d      = cfg.writedata[LED_WIDTH-1:0];
            pioWrite_d = 1'b1;
        end else if (enterRun) begin
            cur_d      = pattern_q;
            pioWrite_d = 1'b1;
        end else if (stepTaken) begin
            case (ctrlMode_q)
                MODE_ROTATE: cur_d = {cur_q[LED_WIDTH-2:0], cur_q[LED_WIDTH-1]};
                MODE_BLINK:  cur_d = (cur_q == pattern_q) ? '0 : pattern_q;
                MODE_COUNT:  cur_d = cur_q + {{(LED_WIDTH-1){1'b0}}, 1'b1};
                default:     cur_d = cur_q;
            endcase
            stepCount_d = stepCount_q + 8'd1;
            pioWrite_d  = 1'b1;
        end

        pioData_d = pioWrite_d ? cur_d : pioData_q;
    end

    // State and registered outputs; the PIO write shows in the first cycle cur holds its new value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrlEnable_q <= 1'b0;
            ctrlMode_q   <= MODE_STATIC;
            period_q     <= RESET_PERIOD;
            pattern_q    <= '0;
            cur_q        <= '0;
            stepCount_q  <= '0;
            state_q      <= ST_IDLE;
            pioWrite_q   <= 1'b0;
            pioData_q    <= '0;
        end else begin
            ctrlEnable_q <= ctrlEnable_d;
            ctrlMode_q   <= ctrlMode_d;
            period_q     <= period_d;
            pattern_q    <= pattern_d;
            cur_q        <= cur_d;
            stepCount_q  <= stepCount_d;
            state_q      <= state_d;
            pioWrite_q   <= pioWrite_d;
            pioData_q    <= pioData_d;
        end
    end

    // Zero-wait config read mux; unused bits read as zero.
    always_comb begin
        readWord = '0;
        case (cfg.address)
            REG_CTRL:    readWord[2:0] = {ctrlMode_q, ctrlEnable_q};
            REG_PERIOD:  readWord[PERIOD_WIDTH-1:0] = period_q;
            REG_PATTERN: readWord[LED_WIDTH-1:0] = pattern_q;
            default: begin
                readWord[LED_WIDTH-1:0] = cur_q;
                readWord[23:16]         = stepCount_q;
            end
        endcase
    end

    // PIO data word is the LED value zero-extended to the bus width.
    always_comb begin
        pioWord = '0;
        pioWord[LED_WIDTH-1:0] = pioData_q;
    end

    assign cfg.readdata   = readWord;
    assign pio.address    = 2'd0;
    assign pio.chipselect = pioWrite_q;
    assign pio.write_n    = !pioWrite_q;
    assign pio.writedata  = pioWord;

endmodule

// File: tb/tb_system_led_sequencer.sv
// Directed bench for the system LED sequencer: reset, static load, rotate,
// count wrap, blink with a pattern/step collision, disable and reset mid-write.
module tb_system_led_sequencer;

    import system_led_seq_pkg::*;

    logic clk;
    logic reset_n;
    logic stepPulse;
    int   compared;
    int   mismatched;
    int   pioWrites;
    int   base;

    system_led_seq_avalon_if cfgBus ();
    system_led_seq_avalon_if pioBus ();

    assign pioBus.readdata = '0;

    system_led_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg        (cfgBus),
        .pio        (pioBus),
        .step_pulse (stepPulse)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every PIO write cycle seen on the bus.
    initial pioWrites = 0;
    always @(negedge clk) begin
        if (reset_n && pioBus.chipselect && !pioBus.write_n) pioWrites++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One config write cycle; returns just after the edge that samples it.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        cfgBus.address    = addr;
        cfgBus.writedata  = data;
        cfgBus.chipselect = 1'b1;
        cfgBus.write_n    = 1'b0;
        tick(1);
        cfgBus.chipselect = 1'b0;
        cfgBus.write_n    = 1'b1;
    endtask

    task automatic readReg(input string tag, input logic [1:0] addr, input logic [31:0] expected);
        cfgBus.address = addr;
        #1;
        checkOutput(tag, cfgBus.readdata, expected);
    endtask

    task automatic checkPio(input string tag, input logic expCs, input logic [31:0] expData);
        checkOutput({tag, "_cs"}, {31'd0, pioBus.chipselect}, {31'd0, expCs});
        checkOutput({tag, "_wn"}, {31'd0, pioBus.write_n}, {31'd0, !expCs});
        checkOutput({tag, "_data"}, pioBus.writedata, expData);
    endtask

    logic [31:0] rotExp [3];
    logic [31:0] cntExp [3];

    initial begin
        compared   = 0;
        mismatched = 0;
        rotExp = '{32'h03, 32'h06, 32'h0C};
        cntExp = '{32'hFF, 32'h00, 32'h01};
        reset_n           = 1'b0;
        cfgBus.address    = 2'd0;
        cfgBus.chipselect = 1'b0;
        cfgBus.write_n    = 1'b1;
        cfgBus.writedata  = '0;

        // Reset state
        tick(3);
        checkPio("reset", 1'b0, 32'h0);
        checkOutput("reset_step", {31'd0, stepPulse}, 32'd0);
        checkOutput("reset_addr", {30'd0, pioBus.address}, 32'd0);
        readReg("reset_ctrl", REG_CTRL, 32'd0);
        readReg("reset_period", REG_PERIOD, 32'd5_000_000);
        readReg("reset_status", REG_STATUS, 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Static pattern load: one write, then silence
        applyStimulus(REG_PATTERN, 32'hA5);
        checkPio("static_write", 1'b1, 32'hA5);
        readReg("static_status", REG_STATUS, 32'hA5);
        tick(1);
        checkPio("static_single", 1'b0, 32'hA5);
        base = pioWrites;
        tick(100);
        checkOutput("static_quiet", pioWrites, base);

        // Rotate with PERIOD=3
        applyStimulus(REG_PERIOD, 32'd3);
        checkPio("period_nowrite", 1'b0, 32'hA5);
        readReg("period_read", REG_PERIOD, 32'd3);
        applyStimulus(REG_PATTERN, 32'h81);
        checkPio("rot_pattern", 1'b1, 32'h81);
        tick(1);
        applyStimulus(REG_CTRL, 32'h3);
        checkPio("rot_load", 1'b1, 32'h81);
        readReg("rot_ctrl", REG_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) begin
            tick(3);
            checkOutput($sformatf("rot_pulse%0d", i), {31'd0, stepPulse}, 32'd1);
            checkPio($sformatf("rot_gap%0d", i), 1'b0, (i == 0) ? 32'h81 : rotExp[i-1]);
            tick(1);
            checkPio($sformatf("rot_step%0d", i), 1'b1, rotExp[i]);
            readReg($sformatf("rot_status%0d", i), REG_STATUS, {8'd0, 8'(i + 1), 8'd0, rotExp[i][7:0]});
        end

        // Disable mid-run: no more writes, cur holds
        applyStimulus(REG_CTRL, 32'h0);
        checkPio("disable", 1'b0, 32'h0C);
        base = pioWrites;
        tick(20);
        checkOutput("disable_quiet", pioWrites, base);
        readReg("disable_status", REG_STATUS, 32'h0003_000C);

        // Count wrap with PERIOD=0: a step every cycle
        applyStimulus(REG_PERIOD, 32'd0);
        applyStimulus(REG_PATTERN, 32'hFE);
        checkPio("cnt_pattern", 1'b1, 32'hFE);
        tick(1);
        applyStimulus(REG_CTRL, 32'h7);
        checkPio("cnt_load", 1'b1, 32'hFE);
        checkOutput("cnt_pulse", {31'd0, stepPulse}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkPio($sformatf("cnt_step%0d", i), 1'b1, cntExp[i]);
        end
        readReg("cnt_status", REG_STATUS, 32'h0006_0001);
        // The disabling cycle is still a RUN cycle, so it takes one last step
        applyStimulus(REG_CTRL, 32'h0);
        checkPio("cnt_last", 1'b1, 32'h02);
        tick(1);
        checkPio("cnt_stopped", 1'b0, 32'h02);
        readReg("cnt_status2", REG_STATUS, 32'h0007_0002);

        // Blink with PERIOD=2, then a pattern write on a step cycle
        applyStimulus(REG_PERIOD, 32'd2);
        applyStimulus(REG_PATTERN, 32'h3C);
        checkPio("blink_pattern", 1'b1, 32'h3C);
        tick(1);
        applyStimulus(REG_CTRL, 32'h5);
        checkPio("blink_load", 1'b1, 32'h3C);
        readReg("blink_ctrl", REG_CTRL, 32'h5);
        tick(3);
        checkPio("blink_off", 1'b1, 32'h00);
        tick(3);
        checkPio("blink_on", 1'b1, 32'h3C);
        tick(2);
        checkOutput("coll_pulse", {31'd0, stepPulse}, 32'd1);
        checkPio("coll_gap", 1'b0, 32'h3C);
        applyStimulus(REG_PATTERN, 32'h0F);
        checkPio("coll_write", 1'b1, 32'h0F);
        readReg("coll_status", REG_STATUS, 32'h0009_000F);
        tick(3);
        checkPio("coll_after", 1'b1, 32'h00);
        readReg("coll_status2", REG_STATUS, 32'h000A_0000);

        // Reset asserted during a write cycle
        reset_n = 1'b0;
        tick(1);
        checkPio("reset_mid", 1'b0, 32'h0);
        checkOutput("reset_mid_step", {31'd0, stepPulse}, 32'd0);
        readReg("reset_mid_status", REG_STATUS, 32'd0);
        readReg("reset_mid_period", REG_PERIOD, 32'd5_000_000);
        reset_n = 1'b1;
        tick(1);

        // STATUS is read-only; reloading an equal value still writes
        applyStimulus(REG_STATUS, 32'hFFFF_FFFF);
        checkPio("status_ro", 1'b0, 32'h0);
        readReg("status_ro_read", REG_STATUS, 32'd0);
        applyStimulus(REG_PATTERN, 32'h0);
        checkPio("equal_load", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/system_led_sequencer.md
Name: system_led_sequencer

Overview:
- Autonomous pattern controller for the system LED PIO. It sits between the Nios config bus and the PIO's Avalon-MM slave.
- The CPU programs mode, period and pattern through a small Avalon-MM slave.
- The block then masters the PIO data register (address 0) with one zero-wait write per LED update, so software no longer toggles LEDs directly.

Parameters:
- LED_WIDTH, 8, width of the PIO output and of the pattern.
- PERIOD_WIDTH, 24, width of the prescaler and PERIOD register.
- RESET_PERIOD, 24'd5_000_000, PERIOD value after reset.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- cfg_address  input  2  config register select
- cfg_chipselect  input  1  config slave select
- cfg_write_n  input  1  config write strobe, active low
- cfg_writedata  input  32  config write data
- cfg_readdata  output  32  config read data, combinational on cfg_address, zero-wait
- pio_address  output  2  to PIO address; constant 0
- pio_chipselect  output  1  to PIO chipselect
- pio_write_n  output  1  to PIO write_n
- pio_writedata  output  32  to PIO writedata, {zeros, led_value}
- step_pulse  output  1  one-cycle pulse on each prescaler step, for debug/IRQ

Behaviour:
- Reset (reset_n sampled low at clk edge): CTRL=0, PERIOD=RESET_PERIOD, PATTERN=0, cur=0, prescaler=0, step_count=0, state=IDLE, pio_chipselect=0, pio_write_n=1, pio_writedata=0, step_pulse=0. Reset asserted mid-write aborts it; the PIO keeps its own state.
- Registers, written when cfg_chipselect && !cfg_write_n:
  - addr0 CTRL: [0] enable; [2:1] mode (0 STATIC, 1 ROTATE, 2 BLINK, 3 COUNT).
  - addr1 PERIOD: [PERIOD_WIDTH-1:0].
  - addr2 PATTERN: [LED_WIDTH-1:0].
  - addr3 STATUS, read-only: [LED_WIDTH-1:0]=cur, [23:16]=step_count (8-bit, wraps 255->0). Writes to addr3 are ignored.
  - Unused read bits are 0.
- Prescaler:
  - Counts only in state RUN. At the cycle where prescaler==PERIOD it clears to 0 and step_pulse=1. Step spacing is PERIOD+1 cycles.
  - PERIOD=0 gives a step every cycle.
  - A PERIOD write clears the prescaler in the same cycle.
- State machine (states IDLE, RUN):
  - IDLE -> RUN when a CTRL write sets enable=1 and mode!=STATIC.
  - RUN -> IDLE when enable=0 or mode=STATIC is written.
  - STATIC never steps.
- Step update of cur:
  - ROTATE: rotate left by 1 (MSB->LSB).
  - BLINK: cur = (cur==PATTERN) ? 0 : PATTERN.
  - COUNT: cur+1, modulo 2^LED_WIDTH.
  - step_count increments on each step.
- Load events:
  - A PATTERN write sets cur=PATTERN in any state and mode, and clears the prescaler.
  - Entering RUN also sets cur=PATTERN and clears the prescaler.
  - If a step and a PATTERN write occur in the same cycle, the write wins and the step is dropped (step_pulse still 1, step_count unchanged).
- PIO write:
  - The cycle after any change of cur (load or step), assert pio_chipselect=1 and pio_write_n=0 for exactly one cycle, with pio_writedata={0,cur}.
  - Latency is 1 cycle from the cur update; the PIO output updates at the next edge.
  - Back-to-back updates (PERIOD=0) produce consecutive write cycles, one per update.
  - A load whose value equals the old cur still issues a write.
- Disabling does not clear cur; the LEDs hold their last value.

Decomposition:
- Package system_led_seq_pkg holds:
  - mode encodings MODE_STATIC/ROTATE/BLINK/COUNT;
  - register address constants REG_CTRL=0, REG_PERIOD=1, REG_PATTERN=2, REG_STATUS=3;
  - state encodings.
- One natural sub-module, system_led_prescaler: counter, PERIOD compare, clear input, step output.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> all pio outputs idle (chipselect=0, write_n=1), STATUS reads 0, PERIOD reads RESET_PERIOD.
- STATIC load: write PATTERN=0xA5 -> exactly one PIO write of 0x000000A5 one cycle later; no further writes over 100 cycles.
- ROTATE: PERIOD=3, PATTERN=0x81, CTRL=enable|ROTATE -> writes 0x81, then 0x03, 0x06, 0x0C spaced 4 cycles apart; STATUS[23:16] increments.
- COUNT wrap with PERIOD=0: PATTERN=0xFE, enable COUNT -> consecutive writes 0xFE, 0xFF, 0x00, 0x01.
- BLINK plus collision: PATTERN=0x3C, PERIOD=2 -> alternating 0x3C/0x00. A PATTERN=0x0F write on a step cycle -> next write is 0x0F and step_count is unchanged.
- Disable mid-run and reset mid-write:
  - CTRL=0 during ROTATE -> no more writes; STATUS cur holds.
  - reset_n=0 on a write cycle -> pio_chipselect=0 at the next edge.
